// File: rtl/circuit1_checker.sv
// Response checker for circuit1: runs a golden z/x model on the tapped a/b/c vectors,
// delays it by LATENCY cycles and compares it against circuit1's outputs over a run.
module circuit1_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [7:0]       c,
    input  logic             in_valid,
    input  logic [7:0]       dut_z,
    input  logic [15:0]      dut_x,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [7:0]       exp_z_err,
    output logic [15:0]      exp_x_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] check_q, check_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [7:0]       exp_z_err_q, exp_z_err_d;
    logic [15:0]      exp_x_err_q, exp_x_err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             vld_q [LATENCY];
    logic             vld_d [LATENCY];
    logic [7:0]       pz_q  [LATENCY];
    logic [7:0]       pz_d  [LATENCY];
    logic [15:0]      px_q  [LATENCY];
    logic [15:0]      px_d  [LATENCY];

    logic [7:0]  mdl_d, mdl_e, mdl_z;
    logic [15:0] mdl_f, mdl_x;
    logic        clear_tags;
    logic        cmp_vld;
    logic        mismatch;

    // Golden model; every operation wraps at its own width.
    always_comb begin
        mdl_d = a + c;
        mdl_e = a + b;
        mdl_z = (mdl_d > mdl_e) ? mdl_d : mdl_e;
        mdl_f = {8'b0, a} * {8'b0, c};
        mdl_x = mdl_f - {8'b0, mdl_d};
    end

    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            vld_d[i] = 1'b0;
            pz_d[i]  = mdl_z;
            px_d[i]  = mdl_x;
        end
        vld_d[0] = in_valid && (state_q == ST_RUN);
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            pz_d[i]  = pz_q[i-1];
            px_d[i]  = px_q[i-1];
        end
        if (clear_tags) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    assign cmp_vld  = (state_q == ST_RUN) && vld_q[LATENCY-1];
    assign mismatch = cmp_vld && ((dut_z != pz_q[LATENCY-1]) || (dut_x != px_q[LATENCY-1]));

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        check_d     = check_q;
        err_d       = err_q;
        first_idx_d = first_idx_q;
        exp_z_err_d = exp_z_err_q;
        exp_x_err_d = exp_x_err_q;
        clear_tags  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_tags  = 1'b1;
                    tgt_d       = target_cnt;
                    check_d     = '0;
                    err_d       = '0;
                    first_idx_d = '0;
                    exp_z_err_d = '0;
                    exp_x_err_d = '0;
                    state_d     = (target_cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmp_vld) begin
                    check_d = check_q + CNT_W'(1);
                    if (mismatch) begin
                        if (err_q != {CNT_W{1'b1}}) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        // err_cnt never returns to zero within a run, so zero marks "no error yet".
                        if (err_q == '0) begin
                            first_idx_d = check_q;
                            exp_z_err_d = pz_q[LATENCY-1];
                            exp_x_err_d = px_q[LATENCY-1];
                        end
                    end
                    if (check_d == tgt_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            check_q     <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            exp_z_err_q <= '0;
            exp_x_err_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                pz_q[i]  <= '0;
                px_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            check_q     <= check_d;
            err_q       <= err_d;
            first_idx_q <= first_idx_d;
            exp_z_err_q <= exp_z_err_d;
            exp_x_err_q <= exp_x_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= vld_d[i];
                pz_q[i]  <= pz_d[i];
                px_q[i]  <= px_d[i];
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign check_cnt     = check_q;
    assign err_cnt       = err_q;
    assign first_err_idx = first_idx_q;
    assign exp_z_err     = exp_z_err_q;
    assign exp_x_err     = exp_x_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_circuit1_checker.sv
// Directed bench for circuit1_checker: a LATENCY=1 instance for runs, faults and reset,
// and a LATENCY=4 instance for gapped in_valid.
module tb_circuit1_checker;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst;
    logic [7:0]  a, b, c;

    logic        start1, in_valid1;
    logic [15:0] tgt1;
    logic [7:0]  dz1;
    logic [15:0] dx1;
    logic        busy1, done1, pass1;
    logic [15:0] chk1, err1, fidx1;
    logic [7:0]  ezerr1;
    logic [15:0] exerr1;
    logic [1:0]  st1;

    logic        start4, in_valid4;
    logic [15:0] tgt4;
    logic [7:0]  dz4;
    logic [15:0] dx4;
    logic        busy4, done4, pass4;
    logic [15:0] chk4, err4, fidx4;
    logic [7:0]  ezerr4;
    logic [15:0] exerr4;
    logic [1:0]  st4;

    circuit1_checker #(.LATENCY(1), .CNT_W(16)) u1 (
        .Clk(Clk), .Rst(Rst), .start(start1), .target_cnt(tgt1),
        .a(a), .b(b), .c(c), .in_valid(in_valid1), .dut_z(dz1), .dut_x(dx1),
        .busy(busy1), .done(done1), .pass(pass1), .check_cnt(chk1), .err_cnt(err1),
        .first_err_idx(fidx1), .exp_z_err(ezerr1), .exp_x_err(exerr1), .state_dbg(st1)
    );

    circuit1_checker #(.LATENCY(4), .CNT_W(16)) u4 (
        .Clk(Clk), .Rst(Rst), .start(start4), .target_cnt(tgt4),
        .a(a), .b(b), .c(c), .in_valid(in_valid4), .dut_z(dz4), .dut_x(dx4),
        .busy(busy4), .done(done4), .pass(pass4), .check_cnt(chk4), .err_cnt(err4),
        .first_err_idx(fidx4), .exp_z_err(ezerr4), .exp_x_err(exerr4), .state_dbg(st4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one cycle on the LATENCY=1 instance: a new vector plus circuit1's response
    // to the previous vector, then waits for the following negedge.
    task automatic cyc1(input logic v, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] vc, input logic [7:0] z, input logic [15:0] x);
        in_valid1 = v;
        a = va; b = vb; c = vc;
        dz1 = z; dx1 = x;
        @(negedge Clk);
    endtask

    task automatic start_run1(input logic [15:0] t);
        in_valid1 = 1'b0;
        start1 = 1'b1;
        tgt1 = t;
        @(negedge Clk);
        start1 = 1'b0;
    endtask

    logic [7:0]  va4 [4] = '{8'd5, 8'd5, 8'd5, 8'd200};
    logic [7:0]  vb4 [4] = '{8'd0, 8'd3, 8'd3, 8'd0};
    logic [7:0]  vc4 [4] = '{8'd2, 8'd2, 8'd3, 8'd100};
    logic [7:0]  ez4 [4] = '{8'd7, 8'd8, 8'd8, 8'd200};
    logic [15:0] ex4 [4] = '{16'd3, 16'd3, 16'd7, 16'd19956};

    initial begin
        Rst = 1'b0;
        a = '0; b = '0; c = '0;
        start1 = 0; in_valid1 = 0; tgt1 = '0; dz1 = '0; dx1 = '0;
        start4 = 0; in_valid4 = 0; tgt4 = '0; dz4 = '0; dx4 = '0;
        repeat (2) @(negedge Clk);

        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_chk", chk1, 0);
        check("rst_state", st1, 0);
        check("rst_chk4", chk4, 0);
        Rst = 1'b1;
        @(negedge Clk);

        // Basic run, with a start pulse (target 0) landing mid-run.
        start_run1(16'd3);
        check("s1_busy", busy1, 1);
        check("s1_state", st1, 1);
        cyc1(1, 5, 0, 2, 8'hAA, 16'hBEEF);
        start1 = 1'b1; tgt1 = 16'd0;
        cyc1(1, 5, 3, 2, 7, 3);
        start1 = 1'b0;
        check("s1_mid_chk", chk1, 1);
        check("s1_mid_busy", busy1, 1);
        cyc1(1, 5, 3, 3, 8, 3);
        check("s1_pre_done", done1, 0);
        cyc1(0, 0, 0, 0, 8, 7);
        check("s1_done", done1, 1);
        check("s1_pass", pass1, 1);
        check("s1_chk", chk1, 3);
        check("s1_err", err1, 0);
        check("s1_busy_off", busy1, 0);
        check("s1_state_done", st1, 2);
        cyc1(1, 5, 0, 2, 0, 0);
        cyc1(0, 0, 0, 0, 0, 0);
        check("s1_frozen_chk", chk1, 3);
        check("s1_frozen_err", err1, 0);

        // Wrap and underflow vectors; restart from DONE.
        start_run1(16'd2);
        check("s2_restart_chk", chk1, 0);
        check("s2_restart_done", done1, 0);
        cyc1(1, 200, 0, 100, 0, 0);
        cyc1(1, 1, 0, 1, 200, 19956);
        cyc1(0, 0, 0, 0, 2, 16'd65535);
        check("s2_done", done1, 1);
        check("s2_pass", pass1, 1);
        check("s2_chk", chk1, 2);

        // Fault on x of the second vector.
        start_run1(16'd3);
        cyc1(1, 5, 0, 2, 0, 0);
        cyc1(1, 5, 3, 2, 7, 3);
        cyc1(1, 5, 3, 3, 8, 8);
        cyc1(0, 0, 0, 0, 8, 7);
        check("s3_done", done1, 1);
        check("s3_pass", pass1, 0);
        check("s3_chk", chk1, 3);
        check("s3_err", err1, 1);
        check("s3_fidx", fidx1, 1);
        check("s3_ezerr", ezerr1, 8);
        check("s3_exerr", exerr1, 3);

        // Zero-length run.
        start_run1(16'd0);
        check("s4_done", done1, 1);
        check("s4_pass", pass1, 1);
        check("s4_chk", chk1, 0);
        check("s4_busy", busy1, 0);

        // Reset mid-run after two compares (one of them failing).
        start_run1(16'd5);
        cyc1(1, 5, 0, 2, 0, 0);
        cyc1(1, 5, 3, 2, 7, 3);
        cyc1(1, 5, 3, 3, 8, 8);
        check("s5_pre_chk", chk1, 2);
        check("s5_pre_err", err1, 1);
        in_valid1 = 1'b0;
        Rst = 1'b0;
        #1;
        check("s5_rst_busy", busy1, 0);
        check("s5_rst_chk", chk1, 0);
        check("s5_rst_err", err1, 0);
        check("s5_rst_fidx", fidx1, 0);
        check("s5_rst_exerr", exerr1, 0);
        check("s5_rst_state", st1, 0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        start_run1(16'd1);
        check("s5_new_chk0", chk1, 0);
        cyc1(1, 5, 0, 2, 0, 0);
        cyc1(0, 0, 0, 0, 7, 3);
        check("s5_new_done", done1, 1);
        check("s5_new_pass", pass1, 1);
        check("s5_new_chk", chk1, 1);

        // LATENCY=4, valid every third cycle; junk on dut_z/x whenever no compare is due.
        in_valid4 = 1'b0;
        start4 = 1'b1;
        tgt4 = 16'd4;
        @(negedge Clk);
        start4 = 1'b0;
        check("s6_busy", busy4, 1);
        for (int k = 0; k < 14; k++) begin
            in_valid4 = ((k % 3) == 0) && (k <= 9);
            if (in_valid4) begin
                a = va4[k/3]; b = vb4[k/3]; c = vc4[k/3];
            end else begin
                a = 8'd9; b = 8'd9; c = 8'd9;
            end
            if ((k >= 4) && (((k - 4) % 3) == 0)) begin
                dz4 = ez4[(k-4)/3];
                dx4 = ex4[(k-4)/3];
            end else begin
                dz4 = 8'hAA;
                dx4 = 16'hBEEF;
            end
            @(negedge Clk);
            if (k == 5) check("s6_chk_k5", chk4, 1);
            if (k == 12) begin
                check("s6_chk_k12", chk4, 3);
                check("s6_notdone_k12", done4, 0);
            end
        end
        in_valid4 = 1'b0;
        check("s6_chk", chk4, 4);
        check("s6_done", done4, 1);
        check("s6_pass", pass4, 1);
        check("s6_err", err4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
